ftoi_pipe: RTL
==============

Name: ftoi_pipe

Overview:
- Pipelined float32-to-int32 converter; the inverse direction of the FPU int-to-float unit.
- Converts IEEE-754 single precision to two's-complement signed 32-bit, rounding to nearest with ties away from zero, saturating on overflow.
- Sits in the FPU execute path behind the FPU issue logic.
- Valid/ready on both sides; fixed 3-stage pipeline with global stall.

Parameters:
- None. Widths are fixed at 32 in, 32 out.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  converter accepts operand this cycle.
- x  in  32  float32 operand {s, e[7:0], m[22:0]}.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  32  signed int32 result.
- flags  out  2  {invalid, inexact}; present only with FTOI_FLAGS_EN.

Behaviour:
- Reset (rst=1 at clk edge): all stage valid bits = 0; out_valid = 0, y = 0, flags = 0. Reset mid-operation discards all in-flight conversions; no result for them ever appears.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv, combinational. All three stages shift together when adv=1 and hold all contents when adv=0. Bubbles propagate as valid=0.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Latency: exactly 3 cycles from input transfer to out_valid when out_ready stays 1. Throughput is 1/cycle.
- While stalled, y and out_valid are stable; x is not sampled.
- S1 (unpack/classify):
  - Register s, e, mant24 = {e!=0, m}.
  - Class: zero/denormal (e==0); small (e<126, incl. denormals); half (e==126); normal (127<=e<=157); ovf (e>=158, incl. inf and NaN); nan (e==255 && m!=0).
- S2 (shift):
  - For normal, sh = e-127 (0..30).
  - Form 32-bit integer part = mant24 << sh >> 23.
  - Round bit = bit just below the integer LSB; sticky = OR of all lower bits.
  - Half class: integer part 0, round=1, sticky = (m!=0).
- S3 (round/sign/saturate):
  - mag = int + round. Ties round away from zero, so 2.5 -> 3 and -2.5 -> -3.
  - y = s ? -mag : mag.
  - Small class -> y = 0, including -0.0 and denormals.
  - ovf class non-NaN: s=0 -> 0x7FFFFFFF; s=1 -> 0x80000000. Since -2^31 (0xCF000000) is in this class, it maps exactly to 0x80000000.
  - NaN -> 0x7FFFFFFF regardless of sign.
  - e==157 needs no rounding, so mag stays < 2^31 and does not carry into bit 31.

Optional Feature:
- Macro FTOI_FLAGS_EN.
- Defined: flags port exists and is registered alongside y with the same valid/stall behaviour.
  - invalid = 1 for ovf class (incl. NaN/inf) except exactly 0xCF000000.
  - inexact = 1 when round|sticky is nonzero for small-nonzero, half, or normal classes.
  - Reset value 0.
- Undefined: flags port and all flag logic absent. y and timing are identical.

Test Plan:
- Rounding: 0x40200000 (2.5) -> y=0x00000003; 0xC0200000 (-2.5) -> 0xFFFFFFFD; 0x3F000000 (0.5) -> 1; 0x3ECCCCCD (0.4) -> 0; 0x80000000 -> 0. Each appears 3 cycles after input transfer.
- Range edges: 0x4EFFFFFF -> 0x7FFFFF80; 0xCF000000 -> 0x80000000 (invalid=0); 0x501502F9 (1e10) -> 0x7FFFFFFF; 0xFF800000 (-inf) -> 0x80000000; 0x7FC00000 (NaN) -> 0x7FFFFFFF (invalid=1).
- Streaming: 8 back-to-back inputs with out_ready=1 -> 8 results on consecutive cycles starting at cycle 3, in order, no gaps.
- Backpressure: out_ready=0 for 5 cycles with pipe full -> in_ready=0, y/out_valid frozen. On release -> results in order, none lost or duplicated.
- Reset mid-flight: 2 operands accepted, rst pulsed at cycle 1 -> out_valid=0 for the following 3 cycles. A post-reset operand 0x3F800000 (1.0) -> y=1 after 3 cycles.
- Flags (FTOI_FLAGS_EN): 0x3FC00000 (1.5) -> y=2, flags=01; 0x41200000 (10.0) -> y=10, flags=00.

Source files
------------

// File: rtl/ftoi_pipe.sv
// Float32 -> int32 converter, round to nearest (ties away from zero), saturating; FTOI_FLAGS_EN adds the {invalid, inexact} flags port.
// Latency: 3 cycles from input transfer to out_valid; throughput one conversion per cycle.
// Backpressure: one global stall, all stages hold while out_valid && !out_ready; in_ready = !out_valid || out_ready.
module ftoi_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
`ifdef FTOI_FLAGS_EN
    ,
    output logic [1:0]  flags
`endif
);
    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: unpack / classify ----------------
    logic [7:0]  x_e;
    logic [22:0] x_m;
    logic        s1_v, s1_s, s1_half, s1_norm, s1_ovf, s1_nan;
    logic [7:0]  s1_e;
    logic [23:0] s1_mant;

    assign x_e = x[30:23];
    assign x_m = x[22:0];

    // Capture operand and its class; anything that is not half/normal/ovf is the small class.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
        end else if (adv) begin
            s1_v    <= in_valid;
            s1_s    <= x[31];
            s1_e    <= x_e;
            s1_mant <= {x_e != 8'd0, x_m};
            s1_half <= (x_e == 8'd126);
            s1_norm <= (x_e >= 8'd127) && (x_e <= 8'd157);
            s1_ovf  <= (x_e >= 8'd158);
            s1_nan  <= (x_e == 8'hFF) && (x_m != 23'd0);
        end
    end

    // ---------------- S2: align ----------------
    logic [4:0]  sh;
    logic [32:0] int_rnd;
    logic [31:0] s2_int_d;
    logic        s2_rnd_d;
    logic        s2_v, s2_s, s2_rnd, s2_ovf, s2_nan;
    logic [31:0] s2_int;

    // For normal operands e-127 is 0..30, so five bits suffice.
    assign sh = 5'(s1_e - 8'd127);
    // Integer part and round bit: bits [54:22] of mant24 << sh (binary point sits at bit 23).
    assign int_rnd = 33'(({31'd0, s1_mant} << sh) >> 22);

    // Half class has an integer part of zero and a set round bit; small and ovf carry nothing.
    always_comb begin
        s2_int_d = 32'd0;
        s2_rnd_d = 1'b0;
        if (s1_norm) begin
            {s2_int_d, s2_rnd_d} = int_rnd;
        end else if (s1_half) begin
            s2_rnd_d = 1'b1;
        end
    end

`ifdef FTOI_FLAGS_EN
    logic [21:0] below_rnd;
    logic        s2_stk_d, s2_minint_d;
    logic        s2_stk, s2_minint;

    assign below_rnd = 22'({31'd0, s1_mant} << sh);
    // -2^31 is the one ovf-class value that converts exactly.
    assign s2_minint_d = s1_s && (s1_e == 8'd158) && (s1_mant[22:0] == 23'd0);

    // Sticky covers every discarded bit; for small operands that is the whole nonzero value.
    always_comb begin
        s2_stk_d = 1'b0;
        if (s1_norm) begin
            s2_stk_d = |below_rnd;
        end else if (s1_half) begin
            s2_stk_d = |s1_mant[22:0];
        end else if (!s1_ovf) begin
            s2_stk_d = |s1_mant;
        end
    end
`endif

    // Stage 2 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v <= 1'b0;
        end else if (adv) begin
            s2_v      <= s1_v;
            s2_s      <= s1_s;
            s2_int    <= s2_int_d;
            s2_rnd    <= s2_rnd_d;
            s2_ovf    <= s1_ovf;
            s2_nan    <= s1_nan;
`ifdef FTOI_FLAGS_EN
            s2_stk    <= s2_stk_d;
            s2_minint <= s2_minint_d;
`endif
        end
    end

    // ---------------- S3: round / sign / saturate ----------------
    logic [31:0] mag, y_d;

    // e<=157 keeps the integer part below 2^31 and e==157 never rounds, so mag cannot reach bit 31.
    assign mag = s2_int + {31'd0, s2_rnd};

    // NaN saturates positive regardless of sign; other ovf values saturate toward their sign.
    always_comb begin
        y_d = s2_s ? (32'd0 - mag) : mag;
        if (s2_nan) begin
            y_d = 32'h7FFF_FFFF;
        end else if (s2_ovf) begin
            y_d = s2_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    // Output register; result only reloads when a valid conversion arrives, so y holds across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= 32'd0;
`ifdef FTOI_FLAGS_EN
            flags     <= 2'b00;
`endif
        end else if (adv) begin
            out_valid <= s2_v;
            if (s2_v) begin
                y     <= y_d;
`ifdef FTOI_FLAGS_EN
                flags <= {s2_ovf && !s2_minint, (s2_rnd || s2_stk) && !s2_ovf};
`endif
            end
        end
    end

endmodule
